// File: rtl/mem_pkg.sv
// Shared memory-side definitions used by the Wishbone interface blocks.
// Provides bus widths and the access-size enum (eDW_*) carried on the bus.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        eDW_BYTE = 2'd0,
        eDW_HALF = 2'd1,
        eDW_WORD = 2'd2
    } data_width_t;

endpackage

// File: rtl/wb_arb_pkg.sv
// Types and constants for the two-requester Wishbone memory arbiter.
package wb_arb_pkg;

    localparam int unsigned TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    // One-hot {data, instr} view of an arbiter state.
    function automatic logic [1:0] grant_onehot(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        if (s == GNT_I) g = 2'b01;
        if (s == GNT_D) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone bus bundle between a master and a slave.
//   master: drives cyc/stb/we/addr/data_write/width, receives data_read/ack
//   slave : the mirror image
interface WISHBONE_IF;
    import mem_pkg::*;

    logic                cyc;
    logic                stb;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data_write;
    logic [DATA_W-1:0]   data_read;
    data_width_t         width;
    logic                ack;

    modport master (
        output cyc, stb, we, addr, data_write, width,
        input  data_read, ack
    );

    modport slave (
        input  cyc, stb, we, addr, data_write, width,
        output data_read, ack
    );
endinterface

// File: rtl/wb_arb_select.sv
// Combinational two-way grant decision for the memory arbiter.
//   req_i, req_d   : pending instruction / data requests
//   last_grant     : owner of the most recent completed (or timed-out) cycle
//   gnt_valid_c    : at least one request present
//   gnt_owner_c    : chosen owner (valid only with gnt_valid_c)
// ROUND_ROBIN=1 alternates on contention, 0 gives data fixed priority.
module wb_arb_select
    import wb_arb_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic       req_i,
    input  logic       req_d,
    input  arb_owner_t last_grant,
    output logic       gnt_valid_c,
    output arb_owner_t gnt_owner_c
);

    always_comb begin
        gnt_valid_c = req_i | req_d;
        gnt_owner_c = OWN_INSTR;
        if (req_i && req_d) begin
            if (ROUND_ROBIN != 0) begin
                gnt_owner_c = (last_grant == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
            end else begin
                gnt_owner_c = OWN_DATA;
            end
        end else if (req_d) begin
            gnt_owner_c = OWN_DATA;
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Shares one downstream memory Wishbone port between the instruction-fetch
// and data masters. A grant covers a whole bus cycle: it is taken in IDLE
// (one arbitration cycle) and held until ack or until the owner drops cyc.
//   clk, rst  : clock, asynchronous active-high reset
//   imem_wb   : instruction requester (read-only, its we is ignored)
//   dmem_wb   : data requester
//   mem_wb    : shared memory port, driven combinationally from the owner
//   oGrant    : registered one-hot owner {data, instr}, 00 when idle
//   oTimeout  : one-cycle pulse after a forced release
// Optional build macro WB_ARB_TIMEOUT_EN adds a watchdog that releases a
// grant after TIMEOUT_CYCLES granted cycles without ack.
module wb_mem_arbiter #(
    parameter int unsigned ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    WISHBONE_IF.slave  imem_wb,
    WISHBONE_IF.slave  dmem_wb,
    WISHBONE_IF.master mem_wb,
    output logic [1:0] oGrant,
    output logic       oTimeout
);
    import wb_arb_pkg::*;
    import mem_pkg::*;

    arb_state_t state;
    arb_state_t state_nxt;
    arb_owner_t last_grant;
    arb_owner_t last_grant_nxt;

    logic       req_i;
    logic       req_d;
    logic       sel_valid;
    arb_owner_t sel_owner;
    logic       granted;
    logic       owner_cyc;
    arb_owner_t cur_owner;
    logic       timeout_fire_c;

    assign req_i     = imem_wb.cyc & imem_wb.stb;
    assign req_d     = dmem_wb.cyc & dmem_wb.stb;
    assign granted   = (state != IDLE);
    assign cur_owner = (state == GNT_D) ? OWN_DATA : OWN_INSTR;
    assign owner_cyc = (state == GNT_D) ? dmem_wb.cyc : imem_wb.cyc;

    wb_arb_select #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_select (
        .req_i       (req_i),
        .req_d       (req_d),
        .last_grant  (last_grant),
        .gnt_valid_c (sel_valid),
        .gnt_owner_c (sel_owner)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] wait_cnt;

    // Granted cycles without ack; IDLE always precedes a grant, so clearing here
    // restarts the count for every new owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (!mem_wb.ack) begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
        end
    end

    // Ack and abort both take precedence over the watchdog.
    assign timeout_fire_c = granted && owner_cyc && !mem_wb.ack && (wait_cnt == TIMEOUT_LAST);
`else
    // Watchdog compiled out: the grant is held until ack or abort.
    assign timeout_fire_c = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // State, last owner and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= OWN_INSTR;
            oGrant     <= 2'b00;
            oTimeout   <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            oGrant     <= grant_onehot(state_nxt);
            oTimeout   <= timeout_fire_c;
        end
    end

    // Next-state: arbitrate in IDLE, release on ack, abort or watchdog.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        unique case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_nxt = (sel_owner == OWN_DATA) ? GNT_D : GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_wb.ack) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = cur_owner;
                end else if (!owner_cyc) begin
                    state_nxt = IDLE;
                end else if (timeout_fire_c) begin
                    // Hand the next contended arbitration to the other master.
                    state_nxt      = IDLE;
                    last_grant_nxt = cur_owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Route the owner onto the memory port; ack returns to the owner only.
    always_comb begin
        mem_wb.cyc         = 1'b0;
        mem_wb.stb         = 1'b0;
        mem_wb.we          = 1'b0;
        mem_wb.addr        = '0;
        mem_wb.data_write  = '0;
        mem_wb.width       = eDW_WORD;
        imem_wb.ack        = 1'b0;
        dmem_wb.ack        = 1'b0;
        imem_wb.data_read  = mem_wb.data_read;
        dmem_wb.data_read  = mem_wb.data_read;
        unique case (state)
            GNT_I: begin
                mem_wb.cyc        = imem_wb.cyc;
                mem_wb.stb        = imem_wb.stb;
                mem_wb.addr       = imem_wb.addr;
                mem_wb.data_write = imem_wb.data_write;
                mem_wb.width      = imem_wb.width;
                imem_wb.ack       = mem_wb.ack;
            end
            GNT_D: begin
                mem_wb.cyc        = dmem_wb.cyc;
                mem_wb.stb        = dmem_wb.stb;
                mem_wb.we         = dmem_wb.we;
                mem_wb.addr       = dmem_wb.addr;
                mem_wb.data_write = dmem_wb.data_write;
                mem_wb.width      = dmem_wb.width;
                dmem_wb.ack       = mem_wb.ack;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: a round-robin instance (index 0) and a fixed-
// priority instance (index 1) see identical stimulus; a transaction-level
// model of each is compared against the DUT outputs on every falling edge.
`timescale 1ns/1ps
module tb_wb_mem_arbiter;
    import mem_pkg::*;

    localparam int unsigned TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus
    logic        i_cyc, i_stb, i_we;
    logic [31:0] i_addr, i_dat;
    data_width_t i_w;
    logic        d_cyc, d_stb, d_we;
    logic [31:0] d_addr, d_dat;
    data_width_t d_w;
    logic        m_ack;
    logic [31:0] m_rdata;

    // Observed DUT outputs, per instance
    logic [1:0]  grant   [2];
    logic        tout    [2];
    logic        i_ack   [2];
    logic        d_ack   [2];
    logic [31:0] i_rd    [2];
    logic [31:0] d_rd    [2];
    logic        m_cyc   [2];
    logic        m_stb   [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_dw    [2];
    logic [1:0]  m_width [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        WISHBONE_IF ib ();
        WISHBONE_IF db ();
        WISHBONE_IF mb ();

        assign ib.cyc = i_cyc;  assign ib.stb = i_stb;  assign ib.we = i_we;
        assign ib.addr = i_addr; assign ib.data_write = i_dat; assign ib.width = i_w;
        assign db.cyc = d_cyc;  assign db.stb = d_stb;  assign db.we = d_we;
        assign db.addr = d_addr; assign db.data_write = d_dat; assign db.width = d_w;
        assign mb.ack = m_ack;  assign mb.data_read = m_rdata;

        assign i_ack[k]   = ib.ack;
        assign d_ack[k]   = db.ack;
        assign i_rd[k]    = ib.data_read;
        assign d_rd[k]    = db.data_read;
        assign m_cyc[k]   = mb.cyc;
        assign m_stb[k]   = mb.stb;
        assign m_we[k]    = mb.we;
        assign m_addr[k]  = mb.addr;
        assign m_dw[k]    = mb.data_write;
        assign m_width[k] = mb.width;

        wb_mem_arbiter #(
            .ROUND_ROBIN    ((k == 0) ? 1 : 0),
            .TIMEOUT_CYCLES (TMO)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .imem_wb  (ib),
            .dmem_wb  (db),
            .mem_wb   (mb),
            .oGrant   (grant[k]),
            .oTimeout (tout[k])
        );
    end

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic string nm(input int k, input string s);
        if (k == 0) return $sformatf("rr.%s", s);
        return $sformatf("fp.%s", s);
    endfunction

    // Transaction-level model: who owns the port (0 none, 1 instr, 2 data),
    // who completed last, granted cycles without ack, pending timeout pulse.
    typedef struct packed {
        logic [1:0] owner;
        logic [1:0] last;
        logic [7:0] tcnt;
        logic       tout;
    } mdl_t;

    mdl_t mdl [2];

    function automatic mdl_t mdl_next(input mdl_t m, input bit rr,
                                      input logic ic, input logic is,
                                      input logic dc, input logic ds, input logic ack);
        mdl_t n;
        bit   ri, rd, ocyc;
        n      = m;
        n.tout = 1'b0;
        ri     = ic && is;
        rd     = dc && ds;
        ocyc   = (m.owner == 2'd1) ? ic : dc;
        if (m.owner == 2'd0) begin
            n.tcnt = 8'd0;
            if (ri && rd)  n.owner = rr ? ((m.last == 2'd1) ? 2'd2 : 2'd1) : 2'd2;
            else if (rd)   n.owner = 2'd2;
            else if (ri)   n.owner = 2'd1;
        end else if (ack) begin
            n.owner = 2'd0;
            n.last  = m.owner;
        end else if (!ocyc) begin
            n.owner = 2'd0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (m.tcnt == 8'(TMO - 1)) begin
            n.owner = 2'd0;
            n.last  = m.owner;
            n.tout  = 1'b1;
        end else begin
            n.tcnt = m.tcnt + 8'd1;
        end
`endif
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) mdl[k] <= '{owner: 2'd0, last: 2'd1, tcnt: 8'd0, tout: 1'b0};
            else     mdl[k] <= mdl_next(mdl[k], (k == 0), i_cyc, i_stb, d_cyc, d_stb, m_ack);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [1:0] o;
                logic [1:0] eg;
                o  = mdl[k].owner;
                eg = (o == 2'd1) ? 2'b01 : ((o == 2'd2) ? 2'b10 : 2'b00);
                check(nm(k, "grant"), 32'(grant[k]), 32'(eg));
                check(nm(k, "mem_cyc"), 32'(m_cyc[k]), 32'((o == 2'd1) ? i_cyc : ((o == 2'd2) ? d_cyc : 1'b0)));
                check(nm(k, "mem_stb"), 32'(m_stb[k]), 32'((o == 2'd1) ? i_stb : ((o == 2'd2) ? d_stb : 1'b0)));
                check(nm(k, "mem_we"), 32'(m_we[k]), 32'((o == 2'd2) ? d_we : 1'b0));
                if (o != 2'd0) begin
                    check(nm(k, "mem_addr"), m_addr[k], (o == 2'd1) ? i_addr : d_addr);
                    check(nm(k, "mem_wdata"), m_dw[k], (o == 2'd1) ? i_dat : d_dat);
                    check(nm(k, "mem_width"), 32'(m_width[k]), 32'((o == 2'd1) ? i_w : d_w));
                end
                check(nm(k, "imem_ack"), 32'(i_ack[k]), 32'((o == 2'd1) && m_ack));
                check(nm(k, "dmem_ack"), 32'(d_ack[k]), 32'((o == 2'd2) && m_ack));
                check(nm(k, "imem_rdata"), i_rd[k], m_rdata);
                check(nm(k, "dmem_rdata"), d_rd[k], m_rdata);
                check(nm(k, "timeout"), 32'(tout[k]), 32'(mdl[k].tout));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0; i_addr = '0; i_dat = '0; i_w = eDW_WORD;
        d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_addr = '0; d_dat = '0; d_w = eDW_WORD;
        m_ack = 1'b0; m_rdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [1:0] order [4];
    int         n_ord;
    int         fp_iack, fp_dack;

    initial begin
        idle_inputs();
        m_rdata = 32'hA5A5_0001;
        step();
        #2;
        // Reset state
        check("reset.grant", 32'(grant[0]), 32'h0);
        check("reset.timeout", 32'(tout[0]), 32'h0);
        check("reset.mem_cyc", 32'(m_cyc[0]), 32'h0);
        check("reset.mem_we", 32'(m_we[0]), 32'h0);
        step();
        rst = 1'b0;
        chk_en = 1'b1;

        // Instruction read alone, memory acks two cycles after the grant
        i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h100;
        #2 check("t1.idle_grant", 32'(grant[0]), 32'h0);
        step(); #2;
        check("t1.grant", 32'(grant[0]), 32'h1);
        check("t1.addr", m_addr[0], 32'h100);
        check("t1.cyc", 32'(m_cyc[0]), 32'h1);
        step(); #2;
        check("t1.no_ack", 32'(i_ack[0]), 32'h0);
        step(); m_ack = 1'b1; #2;
        check("t1.iack", 32'(i_ack[0]), 32'h1);
        check("t1.dack", 32'(d_ack[0]), 32'h0);
        step(); m_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0; #2;
        check("t1.released", 32'(grant[0]), 32'h0);
        step();

        // Simultaneous requests held continuously, memory always acks
        do_reset();
        i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h104;
        d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h2004;
        m_ack = 1'b1;
        n_ord = 0; fp_iack = 0; fp_dack = 0;
        for (int j = 0; j < 4; j++) order[j] = 2'b11;
        for (int j = 0; j < 8; j++) begin
            #2;
            if (grant[0] != 2'b00 && n_ord < 4) begin
                order[n_ord] = grant[0];
                n_ord++;
            end
            if (i_ack[1]) fp_iack++;
            if (d_ack[1]) fp_dack++;
            step();
        end
        check("t2.rr_grants", 32'(n_ord), 32'd4);
        check("t2.rr_order0", 32'(order[0]), 32'h2);
        check("t2.rr_order1", 32'(order[1]), 32'h1);
        check("t2.rr_order2", 32'(order[2]), 32'h2);
        check("t2.rr_order3", 32'(order[3]), 32'h1);
        check("t2.fp_instr_starved", 32'(fp_iack), 32'd0);
        check("t2.fp_data_acks", 32'(fp_dack), 32'd4);
        idle_inputs();
        step();

        // Data write while instruction fetch waits
        do_reset();
        i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h300;
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_dat = 32'hDEADBEEF;
        step(); #2;
        check("t3.grant_d", 32'(grant[0]), 32'h2);
        check("t3.we", 32'(m_we[0]), 32'h1);
        check("t3.wdata", m_dw[0], 32'hDEADBEEF);
        check("t3.addr", m_addr[0], 32'h2000);
        check("t3.iack_stall", 32'(i_ack[0]), 32'h0);
        step(); m_ack = 1'b1; #2;
        check("t3.dack", 32'(d_ack[0]), 32'h1);
        check("t3.iack_hold", 32'(i_ack[0]), 32'h0);
        step(); m_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; #2;
        check("t3.idle_we", 32'(m_we[0]), 32'h0);
        step(); #2;
        check("t3.grant_i", 32'(grant[0]), 32'h1);
        check("t3.addr_i", m_addr[0], 32'h300);
        check("t3.we_i", 32'(m_we[0]), 32'h0);
        m_ack = 1'b1;
        step(); idle_inputs(); step();

        // Reset during a data grant
        do_reset();
        d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h2010;
        step(); #2;
        check("t4.cyc_before", 32'(m_cyc[0]), 32'h1);
        rst = 1'b1;
        #1 m_ack = 1'b1;
        #1;
        check("t4.cyc_async", 32'(m_cyc[0]), 32'h0);
        check("t4.grant", 32'(grant[0]), 32'h0);
        check("t4.dack", 32'(d_ack[0]), 32'h0);
        check("t4.iack", 32'(i_ack[0]), 32'h0);
        #3 rst = 1'b0; m_ack = 1'b0;
        step(); #2;
        check("t4.regrant", 32'(grant[0]), 32'h2);
        d_cyc = 1'b0; d_stb = 1'b0;
        step(); step();

        // Unacknowledged instruction read with a data request pending
        do_reset();
        i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h400;
        step();
        d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h2020;
`ifdef WB_ARB_TIMEOUT_EN
        step(); step(); step(); #2;
        check("t5.still_i", 32'(grant[0]), 32'h1);
        check("t5.no_pulse", 32'(tout[0]), 32'h0);
        step(); #2;
        check("t5.pulse", 32'(tout[0]), 32'h1);
        check("t5.released", 32'(grant[0]), 32'h0);
        check("t5.iack", 32'(i_ack[0]), 32'h0);
        step(); m_ack = 1'b1; #2;
        check("t5.grant_d", 32'(grant[0]), 32'h2);
        check("t5.dack", 32'(d_ack[0]), 32'h1);
        check("t5.pulse_once", 32'(tout[0]), 32'h0);
        step(); m_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
        step(); #2;
        check("t5.regrant_i", 32'(grant[0]), 32'h1);
        i_cyc = 1'b0; i_stb = 1'b0;
        step(); step();
`else
        for (int j = 0; j < 10; j++) begin
            step(); #2;
            check("t5.hold_i", 32'(grant[0]), 32'h1);
            check("t5.no_timeout", 32'(tout[0]), 32'h0);
        end
        i_cyc = 1'b0; i_stb = 1'b0;
        step(); #2;
        check("t5.abort_idle", 32'(grant[0]), 32'h0);
        step(); #2;
        check("t5.grant_d", 32'(grant[0]), 32'h2);
        m_ack = 1'b1;
        step(); d_cyc = 1'b0; d_stb = 1'b0; m_ack = 1'b0;
        step();
`endif

        // Randomized traffic, including aborts and occasional async resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) i_cyc = ~i_cyc;
            if ($urandom_range(0, 3) == 0) d_cyc = ~d_cyc;
            i_stb   = i_cyc ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            d_stb   = d_cyc ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            i_we    = 1'($urandom_range(0, 1));
            d_we    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) i_addr = $urandom;
            if ($urandom_range(0, 2) == 0) d_addr = $urandom;
            i_dat   = $urandom;
            d_dat   = $urandom;
            i_w     = data_width_t'(2'($urandom_range(0, 2)));
            d_w     = data_width_t'(2'($urandom_range(0, 2)));
            m_ack   = ($urandom_range(0, 3) == 0);
            m_rdata = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b1;
                #5 rst = 1'b0;
            end
            step();
        end

        idle_inputs();
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-requester Wishbone arbiter sharing one memory port between the instruction fetch master and the data/load-store master.
- Sits between the IMEM and DMEM interface blocks and the single downstream memory Wishbone slave.
- Sequences whole bus cycles: a grant is held from arbitration until ack or abort. Requests are then routed to the memory port, and ack is steered back to the owner only.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate on simultaneous requests; 0 = fixed priority, data master wins.
- TIMEOUT_CYCLES, 255, cycles without ack before forced release (used only with the optional feature); 8-bit counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- imem_wb  interface  WISHBONE_IF.slave  instruction-fetch requester (read-only; we ignored)
- dmem_wb  interface  WISHBONE_IF.slave  data requester (read/write, any width)
- mem_wb  interface  WISHBONE_IF.master  shared downstream memory port
- oGrant  output  2  one-hot current owner, {data, instr}; 2'b00 when idle
- oTimeout  output  1  single-cycle pulse on forced release; tied 0 when the feature is compiled out

Behaviour:
- State machine states: IDLE, GNT_I, GNT_D. State register and last_grant register.
- Reset (async, rst=1): state=IDLE, last_grant=INSTR, oGrant=00, oTimeout=0. mem_wb.cyc/stb/we=0. imem_wb.ack=dmem_wb.ack=0.
- IDLE:
  - Sample imem_wb.cyc&stb and dmem_wb.cyc&stb.
  - Only one request present: next state grants it.
  - Both requests present, ROUND_ROBIN=1: grant the master that is not last_grant.
  - Both requests present, ROUND_ROBIN=0: grant data.
  - No request: stay in IDLE.
  - Arbitration costs exactly 1 cycle. mem_wb.cyc/stb stay 0 while in IDLE.
- GNT_x:
  - mem_wb.addr, we, stb, cyc, width and data_write are driven combinationally from owner x.
  - The non-owner sees ack=0 and therefore stalls.
  - mem_wb.data_read is broadcast to both requesters.
  - Owner ack = mem_wb.ack, same cycle (combinational).
- Release conditions:
  - Cycle with mem_wb.ack=1: next state IDLE, last_grant <= x.
  - Owner drops cyc (abort) before ack: next state IDLE, last_grant unchanged.
  - A requester holding cyc continuously is re-arbitrated in IDLE. Best-case throughput is one transfer per 2 cycles per arbitration.
- Simultaneous events:
  - ack and a new request from the non-owner in the same cycle: the new request is only considered in the following IDLE cycle.
  - ack and abort in the same cycle: treated as a completed transfer.
- Non-owner request signals never reach mem_wb. The non-owner must hold its request stable while stalled (standard Wishbone).
- rst asserted mid-cycle: immediate return to IDLE; mem_wb.cyc deasserts asynchronously; the in-flight transfer is discarded.
- oGrant reflects the registered state.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter clears on entering GNT_x and increments each granted cycle without ack.
  - When count == TIMEOUT_CYCLES-1 and no ack: force next state IDLE, pulse oTimeout for 1 cycle, set last_grant <= x so the other master goes next. No ack is given to the owner, which remains stalled and retries.
- Disabled: no counter; the grant is held indefinitely until ack or abort; oTimeout=0.

Decomposition:
- Package wb_arb_pkg:
  - arb_state_t enum {IDLE, GNT_I, GNT_D}
  - arb_owner_t enum {OWN_INSTR, OWN_DATA}
  - TIMEOUT_W=8 constant
- The existing data-width enum (eDW_*) is reused from the shared memory package.
- One sub-module, wb_arb_select: purely combinational two-way grant decision from (req_i, req_d, last_grant, ROUND_ROBIN). It is unit-tested separately.

Test Plan:
- Only imem requests addr 0x100; memory acks 2 cycles after stb:
  - Cycle 1: oGrant=01.
  - mem_wb.addr=0x100 until ack; imem ack in the ack cycle.
  - Then IDLE for 1 cycle.
- Both request at the same edge after reset, ROUND_ROBIN=1:
  - Data granted first (last_grant=INSTR); then instr.
  - The grant order alternates D,I,D,I over 4 transfers.
- Same stimulus with ROUND_ROBIN=0: data granted on every arbitration while it keeps requesting; instr starved, and the bench checks that starvation occurs.
- Data write 0xDEADBEEF to 0x2000 while imem is waiting: mem_wb.we=1 and data_write=0xDEADBEEF during GNT_D only; imem ack stays 0 throughout.
- rst pulsed while in GNT_D before ack: mem_wb.cyc=0 in the same cycle, oGrant=00, state=IDLE; no ack is delivered to either requester.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, memory never acks an imem read:
  - oTimeout pulses after 4 granted cycles.
  - A pending dmem request is granted next.
  - imem is re-granted afterwards.
